// File: rtl/calc_sequencer.sv
// Keypad calculator sequencer: operand entry, ALU start/done handshake with
// watchdog, result/error display select. Every output is driven by a flop.
module calc_sequencer #(
  parameter int DIGITS  = 3,
  parameter int TIMEOUT = 1024
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       dig_strobe,
  input  logic       op_strobe,
  input  logic [1:0] op_code,
  input  logic       eq_strobe,
  input  logic       bksp_strobe,
  input  logic       clr_strobe,
  input  logic       alu_done,
  input  logic       alu_err,
  output logic       load_A,
  output logic       load_B,
  output logic       bksp_A,
  output logic       bksp_B,
  output logic       clear_AB,
  output logic       alu_start,
  output logic [1:0] op_reg,
  output logic [1:0] display_select,
  output logic       busy,
  output logic       error
);

  localparam int CW = $clog2(DIGITS + 1);
  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIGITS);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ENTER_A,
    ENTER_B,
    EXEC,
    SHOW_RES,
    ERROR
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt_a, cnt_a_n;
  logic [CW-1:0] cnt_b, cnt_b_n;
  logic [WW-1:0] wd, wd_n;
  logic [1:0]    op_n;
  logic          pend, pend_n;
  logic          load_a_n, load_b_n, bksp_a_n, bksp_b_n, clear_ab_n, alu_start_n;
  logic [1:0]    disp_n;

  always_comb begin
    state_n     = state;
    cnt_a_n     = cnt_a;
    cnt_b_n     = cnt_b;
    op_n        = op_reg;
    wd_n        = '0;
    pend_n      = 1'b0;
    load_a_n    = 1'b0;
    load_b_n    = 1'b0;
    bksp_a_n    = 1'b0;
    bksp_b_n    = 1'b0;
    clear_ab_n  = 1'b0;
    alu_start_n = 1'b0;

    // The deferred first digit after a result outranks every strobe, clr included.
    if (pend) begin
      load_a_n = 1'b1;
      cnt_a_n  = CW'(1);
    end else if (clr_strobe) begin
      clear_ab_n = 1'b1;
      cnt_a_n    = '0;
      cnt_b_n    = '0;
      op_n       = '0;
      state_n    = ENTER_A;
    end else begin
      unique case (state)
        ENTER_A: begin
          if (eq_strobe) begin
            // equals has no meaning before an operator
          end else if (op_strobe) begin
            if (cnt_a != '0) begin
              op_n    = op_code;
              state_n = ENTER_B;
            end
          end else if (bksp_strobe) begin
            if (cnt_a != '0) begin
              bksp_a_n = 1'b1;
              cnt_a_n  = cnt_a - 1'b1;
            end
          end else if (dig_strobe) begin
            if (cnt_a < CNT_MAX) begin
              load_a_n = 1'b1;
              cnt_a_n  = cnt_a + 1'b1;
            end
          end
        end

        ENTER_B: begin
          if (eq_strobe) begin
            if (cnt_b != '0) begin
              alu_start_n = 1'b1;
              state_n     = EXEC;
            end
          end else if (op_strobe) begin
            op_n = op_code;
          end else if (bksp_strobe) begin
            if (cnt_b != '0) begin
              bksp_b_n = 1'b1;
              cnt_b_n  = cnt_b - 1'b1;
            end else begin
              state_n = ENTER_A;
            end
          end else if (dig_strobe) begin
            if (cnt_b < CNT_MAX) begin
              load_b_n = 1'b1;
              cnt_b_n  = cnt_b + 1'b1;
            end
          end
        end

        EXEC: begin
          wd_n = wd + 1'b1;
          // alu_start high marks the first EXEC cycle, where alu_done is not yet valid
          if (!alu_start && alu_done) begin
            state_n = alu_err ? ERROR : SHOW_RES;
          end else if (wd == WD_LAST) begin
            state_n = ERROR;
          end
        end

        SHOW_RES: begin
          if (dig_strobe && !eq_strobe && !op_strobe && !bksp_strobe) begin
            clear_ab_n = 1'b1;
            cnt_a_n    = '0;
            cnt_b_n    = '0;
            pend_n     = 1'b1;
            state_n    = ENTER_A;
          end
        end

        ERROR: begin
        end

        default: state_n = ENTER_A;
      endcase
    end
  end

  always_comb begin
    disp_n = 2'd0;
    unique case (state_n)
      ENTER_A:  disp_n = 2'd0;
      ENTER_B:  disp_n = 2'd1;
      EXEC:     disp_n = 2'd1;
      SHOW_RES: disp_n = 2'd2;
      ERROR:    disp_n = 2'd3;
      default:  disp_n = 2'd0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ENTER_A;
      cnt_a          <= '0;
      cnt_b          <= '0;
      wd             <= '0;
      pend           <= 1'b0;
      op_reg         <= '0;
      load_A         <= 1'b0;
      load_B         <= 1'b0;
      bksp_A         <= 1'b0;
      bksp_B         <= 1'b0;
      clear_AB       <= 1'b0;
      alu_start      <= 1'b0;
      display_select <= '0;
      busy           <= 1'b0;
      error          <= 1'b0;
    end else begin
      state          <= state_n;
      cnt_a          <= cnt_a_n;
      cnt_b          <= cnt_b_n;
      wd             <= wd_n;
      pend           <= pend_n;
      op_reg         <= op_n;
      load_A         <= load_a_n;
      load_B         <= load_b_n;
      bksp_A         <= bksp_a_n;
      bksp_B         <= bksp_b_n;
      clear_AB       <= clear_ab_n;
      alu_start      <= alu_start_n;
      display_select <= disp_n;
      busy           <= (state_n == EXEC);
      error          <= (state_n == ERROR);
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: hand-computed responses checked one cycle
// after each strobe, sampled 1ns after the rising edge.
module tb_calc_sequencer;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       dig_strobe = 1'b0, op_strobe = 1'b0, eq_strobe = 1'b0;
  logic       bksp_strobe = 1'b0, clr_strobe = 1'b0;
  logic [1:0] op_code = 2'd0;
  logic       alu_done = 1'b0, alu_err = 1'b0;
  logic       load_A, load_B, bksp_A, bksp_B, clear_AB, alu_start, busy, error;
  logic [1:0] op_reg, display_select;
  logic [7:0] pv;

  int unsigned total = 0;
  int unsigned bad = 0;

  calc_sequencer #(.DIGITS(3), .TIMEOUT(16)) dut (
    .clock(clock), .reset_n(reset_n),
    .dig_strobe(dig_strobe), .op_strobe(op_strobe), .op_code(op_code),
    .eq_strobe(eq_strobe), .bksp_strobe(bksp_strobe), .clr_strobe(clr_strobe),
    .alu_done(alu_done), .alu_err(alu_err),
    .load_A(load_A), .load_B(load_B), .bksp_A(bksp_A), .bksp_B(bksp_B),
    .clear_AB(clear_AB), .alu_start(alu_start), .op_reg(op_reg),
    .display_select(display_select), .busy(busy), .error(error)
  );

  always #5 clock = ~clock;

  // bit order: load_A load_B bksp_A bksp_B clear_AB alu_start busy error
  assign pv = {load_A, load_B, bksp_A, bksp_B, clear_AB, alu_start, busy, error};

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%02h expected=%02h", tag, got, exp);
    end
  endtask

  task automatic dig();
    dig_strobe = 1'b1; tick(); dig_strobe = 1'b0;
  endtask

  task automatic op(input logic [1:0] code);
    op_code = code; op_strobe = 1'b1; tick(); op_strobe = 1'b0;
  endtask

  task automatic eq();
    eq_strobe = 1'b1; tick(); eq_strobe = 1'b0;
  endtask

  task automatic bksp();
    bksp_strobe = 1'b1; tick(); bksp_strobe = 1'b0;
  endtask

  task automatic clr();
    clr_strobe = 1'b1; tick(); clr_strobe = 1'b0;
  endtask

  initial begin
    tick(); tick();
    chk("rst_pulses", pv, 8'h00);
    chk("rst_disp", {6'd0, display_select}, 8'd0);
    chk("rst_op", {6'd0, op_reg}, 8'd0);
    reset_n = 1'b1;
    tick();

    // four back-to-back digits into a three-digit operand
    dig_strobe = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("dig_a%0d", i), pv, (i < 3) ? 8'h80 : 8'h00);
    end
    dig_strobe = 1'b0;
    chk("disp_a", {6'd0, display_select}, 8'd0);
    bksp();
    chk("bksp_a", pv, 8'h20);
    tick();
    chk("bksp_a_width", pv, 8'h00);

    op(2'd1);
    chk("op_disp", {6'd0, display_select}, 8'd1);
    chk("op_reg1", {6'd0, op_reg}, 8'd1);
    bksp();
    chk("bksp_b0_pulse", pv, 8'h00);
    chk("bksp_b0_disp", {6'd0, display_select}, 8'd0);
    chk("bksp_b0_op", {6'd0, op_reg}, 8'd1);
    op(2'd2);
    chk("reenter_b", {6'd0, display_select}, 8'd1);
    op(2'd1);
    chk("op_replace", {6'd0, op_reg}, 8'd1);
    eq();
    chk("eq_b0_ignored", pv, 8'h00);
    dig();
    chk("load_b0", pv, 8'h40);
    dig();
    chk("load_b1", pv, 8'h40);
    eq();
    chk("alu_start", pv, 8'h06);
    alu_done = 1'b1; tick(); alu_done = 1'b0;
    chk("done_with_start_ignored", pv, 8'h02);
    dig();
    chk("dig_in_exec", pv, 8'h02);
    tick();
    chk("exec_wait", pv, 8'h02);
    alu_done = 1'b1; tick(); alu_done = 1'b0;
    chk("res_disp", {6'd0, display_select}, 8'd2);
    chk("res_idle", pv, 8'h00);

    // digit after a result: clear now, deferred load next, colliding digit dropped
    dig();
    chk("res_dig_clear", pv, 8'h08);
    chk("res_dig_disp", {6'd0, display_select}, 8'd0);
    dig();
    chk("res_dig_load", pv, 8'h80);
    tick();
    chk("res_dig_idle", pv, 8'h00);
    bksp();
    chk("cnt1_bksp", pv, 8'h20);
    bksp();
    chk("cnt0_bksp_ignored", pv, 8'h00);
    op(2'd3);
    chk("op_cnt0_ignored", {6'd0, display_select}, 8'd0);

    // watchdog expiry
    dig();
    op(2'd2);
    dig();
    eq();
    chk("wd_start", pv, 8'h06);
    for (int i = 1; i < 16; i++) begin
      if (i == 3) begin
        op_code = 2'd3;
        dig_strobe = 1'b1; op_strobe = 1'b1; eq_strobe = 1'b1;
      end
      tick();
      if (i == 5) begin
        dig_strobe = 1'b0; op_strobe = 1'b0; eq_strobe = 1'b0;
      end
      chk($sformatf("wd_run%0d", i), pv, 8'h02);
    end
    chk("wd_op_kept", {6'd0, op_reg}, 8'd2);
    tick();
    chk("wd_error", pv, 8'h01);
    chk("wd_disp", {6'd0, display_select}, 8'd3);
    dig();
    chk("err_dig_ignored", pv, 8'h01);
    clr();
    chk("err_clr", pv, 8'h08);
    chk("err_clr_disp", {6'd0, display_select}, 8'd0);
    chk("err_clr_op", {6'd0, op_reg}, 8'd0);

    // clr and dig together in SHOW_RES
    dig();
    op(2'd0);
    dig();
    eq();
    tick();
    alu_done = 1'b1; tick(); alu_done = 1'b0;
    chk("res2_disp", {6'd0, display_select}, 8'd2);
    clr_strobe = 1'b1; dig_strobe = 1'b1; tick();
    clr_strobe = 1'b0; dig_strobe = 1'b0;
    chk("clr_dig_clear", pv, 8'h08);
    tick();
    chk("clr_dig_noload", pv, 8'h00);

    // ALU error
    dig();
    op(2'd3);
    dig();
    eq();
    tick();
    alu_done = 1'b1; alu_err = 1'b1; tick(); alu_done = 1'b0; alu_err = 1'b0;
    chk("alu_err", pv, 8'h01);
    chk("alu_err_disp", {6'd0, display_select}, 8'd3);
    clr();
    chk("alu_err_clr", pv, 8'h08);

    // asynchronous reset mid-EXEC
    dig();
    op(2'd2);
    dig();
    eq();
    tick();
    chk("pre_rst_busy", pv, 8'h02);
    #3 reset_n = 1'b0;
    #1;
    chk("async_rst_pulses", pv, 8'h00);
    chk("async_rst_disp", {6'd0, display_select}, 8'd0);
    chk("async_rst_op", {6'd0, op_reg}, 8'd0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("post_rst_pulses", pv, 8'h00);
    chk("post_rst_disp", {6'd0, display_select}, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Sequencing controller for the keypad calculator datapath. It consumes the single-cycle key, operator, equals, backspace and clear strobes, and steps the machine through operand A entry, operand B entry, ALU execution and result display. It drives the per-operand bcdreg load, backspace and clear controls, the ALU start/done handshake and the displaymux select. It bounds each operand to the bcdreg digit capacity and recovers from ALU errors and timeouts.

## Interface
- DIGITS, 3: maximum digits per operand (bcdreg depth), 1..7
- TIMEOUT, 1024: cycles allowed in EXEC before a forced error, ≥2
- clock  in  1  system clock; all state changes on its rising edge
- reset_n  in  1  reset, asynchronous and active-low
- dig_strobe  in  1  one-cycle pulse, digit key pressed (keycode held stable by keypad for ≥2 cycles)
- op_strobe  in  1  one-cycle pulse, operator key pressed
- op_code  in  2  operator, sampled with op_strobe: 0 add, 1 sub, 2 mul, 3 div
- eq_strobe  in  1  one-cycle pulse, equals pressed
- bksp_strobe  in  1  one-cycle pulse, backspace pressed
- clr_strobe  in  1  one-cycle pulse, clear-all pressed
- alu_done  in  1  ALU result valid (pulse or level, sampled only in EXEC)
- alu_err  in  1  ALU overflow/divide-by-zero, qualified by alu_done
- load_A, load_B  out  1 each  one-cycle shift-in of current keycode into operand register
- bksp_A, bksp_B  out  1 each  one-cycle backspace of operand register
- clear_AB  out  1  one-cycle clear of both operand registers
- alu_start  out  1  one-cycle ALU start
- op_reg  out  2  latched operator
- display_select  out  2  0 operand A, 1 operand B, 2 result, 3 error pattern
- busy  out  1  high while in EXEC
- error  out  1  high while in ERROR

## Operation
- States: ENTER_A, ENTER_B, EXEC, SHOW_RES, ERROR. Digit counters cnt_A and cnt_B, each 0..DIGITS.
- Priority within one cycle: clr > eq > op > bksp > dig. At most one action is taken per cycle; lower-priority strobes in the same cycle are dropped.
- clr_strobe (any state): pulse clear_AB, zero both counters, op_reg=0, go to ENTER_A.
- ENTER_A:
  - dig with cnt_A<DIGITS: pulse load_A, cnt_A+1. dig at cnt_A=DIGITS is ignored.
  - bksp with cnt_A>0: pulse bksp_A, cnt_A-1. bksp at 0 is ignored.
  - op with cnt_A>0: op_reg←op_code, go to ENTER_B. op at cnt_A=0 is ignored.
  - eq is ignored.
- ENTER_B:
  - dig and bksp behave as in ENTER_A, applied to load_B, bksp_B and cnt_B.
  - bksp at cnt_B=0: return to ENTER_A; op_reg is kept.
  - op: op_reg←op_code (replace operator), stay in ENTER_B.
  - eq with cnt_B>0: pulse alu_start, go to EXEC. eq at cnt_B=0 is ignored.
- EXEC:
  - All strobes except clr are ignored. The watchdog counter starts at 0 on entry.
  - alu_done&!alu_err: go to SHOW_RES.
  - alu_done&alu_err: go to ERROR.
  - Watchdog reaching TIMEOUT-1 without alu_done: go to ERROR.
- SHOW_RES:
  - dig: pulse clear_AB, zero counters, go to ENTER_A, and pulse load_A on the next cycle with cnt_A=1. This pending load is not lost even if a strobe arrives in that cycle; such a strobe is dropped.
  - op, eq and bksp are ignored.
- ERROR: only clr exits.
- display_select is a function of state: ENTER_A→0, ENTER_B→1, EXEC→1, SHOW_RES→2, ERROR→3.

## Timing
- All outputs are registered. Strobe in cycle N gives its response pulse in cycle N+1, exactly one cycle wide.
- alu_start is asserted in the first cycle of EXEC. alu_done is honoured from the cycle after alu_start onward; alu_done coincident with alu_start is ignored.
- Reset values: state ENTER_A, cnt_A=cnt_B=0, op_reg=0, display_select=0, and all pulses, busy and error at 0.
- Reset asserted mid-EXEC returns immediately to these values; no alu_start is reissued.
- Back-to-back strobes on consecutive cycles are each processed.

## Test plan
- Reset, 4 dig strobes → exactly 3 load_A pulses, 4th ignored; display_select=0; bksp → bksp_A, cnt_A=2.
- A="12", op_strobe op_code=1, 2 digs, eq → op_reg=1, 2 load_B pulses, single alu_start; alu_done 5 cycles later → display_select=2, busy low.
- In ENTER_B with cnt_B=0, bksp → state ENTER_A, display_select=0, op_reg unchanged; op at cnt_A=0 → no transition.
- EXEC with alu_done never asserted → error=1 after TIMEOUT cycles; dig, op and eq ignored; clr → clear_AB pulse, ENTER_A.
- SHOW_RES, dig_strobe → clear_AB at N+1, load_A at N+2, cnt_A=1; clr and dig in the same cycle → only clear_AB.
- alu_done with alu_err=1 → display_select=3; reset_n low mid-EXEC → all outputs at reset values asynchronously.
